// File: rtl/bmi_bit_extract_seq_if.sv
// rtl/bmi_bit_extract_seq_if.sv - issue handshake and bit-select mux bundle for the PEXT engine
interface bmi_bit_extract_seq_if;
  logic        start;
  logic [63:0] src;
  logic [63:0] mask;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [6:0]  popcnt;
  logic [63:0] mux_a;
  logic [5:0]  mux_sel;
  logic        mux_out;

  modport master (
    output start, src, mask, mux_out,
    input  busy, done, result, popcnt, mux_a, mux_sel
  );

  modport slave (
    input  start, src, mask, mux_out,
    output busy, done, result, popcnt, mux_a, mux_sel
  );
endinterface

// File: rtl/bmi_bit_extract_seq.sv
// rtl/bmi_bit_extract_seq.sv - sequential parallel-bit-extract engine driving an external 64:1 mux
module bmi_bit_extract_seq #(
  parameter int MUX_LAT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  bmi_bit_extract_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] mux_a_q;
  logic [63:0] msk;
  logic [63:0] result_q;
  logic [6:0]  popcnt_q;
  logic [5:0]  idx;
  logic [5:0]  k;
  logic        tag_vld;
  logic        tag_bit;
  logic        accept;
  logic        last_idx;
  logic        capture;

  // msk shifts right once per scanned bit, so msk[0] is the mask bit at idx
  // and an empty msk[63:1] marks the highest set bit.
  assign accept   = (state == IDLE) && bus.start;
  assign last_idx = (msk[63:1] == 63'd0);
  assign capture  = ((state == SCAN) || (state == DRAIN)) && tag_vld && tag_bit;

  generate
    if (MUX_LAT == 0) begin : g_direct
      assign tag_vld = (state == SCAN);
      assign tag_bit = msk[0];
    end else begin : g_delay
      logic tag_vld_q;
      logic tag_bit_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_vld_q <= 1'b0;
          tag_bit_q <= 1'b0;
        end else begin
          tag_vld_q <= (state == SCAN);
          tag_bit_q <= msk[0];
        end
      end
      assign tag_vld = tag_vld_q;
      assign tag_bit = tag_bit_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.mask == 64'd0) ? DONE : SCAN;
      SCAN:    if (last_idx) state_nxt = (MUX_LAT == 0) ? DONE : DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.mux_sel = 6'd0;
    case (state)
      SCAN: begin
        bus.busy    = 1'b1;
        bus.mux_sel = idx;
      end
      DRAIN: begin
        bus.busy    = 1'b1;
        bus.mux_sel = idx;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // idx stops on the last index so DRAIN keeps the mux pointed at H.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_a_q  <= 64'd0;
      msk      <= 64'd0;
      result_q <= 64'd0;
      popcnt_q <= 7'd0;
      idx      <= 6'd0;
      k        <= 6'd0;
    end else if (accept) begin
      mux_a_q  <= bus.src;
      msk      <= bus.mask;
      result_q <= 64'd0;
      popcnt_q <= 7'd0;
      idx      <= 6'd0;
      k        <= 6'd0;
    end else begin
      if (state == SCAN) begin
        msk <= msk >> 1;
        if (!last_idx) idx <= idx + 6'd1;
      end
      if (capture) begin
        result_q[k] <= bus.mux_out;
        k           <= k + 6'd1;
        popcnt_q    <= popcnt_q + 7'd1;
      end
    end
  end

  assign bus.mux_a  = mux_a_q;
  assign bus.result = result_q;
  assign bus.popcnt = popcnt_q;

endmodule

// File: tb/tb_bmi_bit_extract_seq.sv
// tb/tb_bmi_bit_extract_seq.sv - directed and random PEXT checks on MUX_LAT=1 and MUX_LAT=0 engines
module tb_bmi_bit_extract_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] src = 64'd0;
  logic [63:0] mask = 64'd0;
  int          total = 0;
  int          bad = 0;

  bmi_bit_extract_seq_if b1 ();
  bmi_bit_extract_seq_if b0 ();

  assign b1.start = start;
  assign b1.src   = src;
  assign b1.mask  = mask;
  assign b0.start = start;
  assign b0.src   = src;
  assign b0.mask  = mask;

  // registered mux for the one-cycle engine, combinational mux for the zero-latency one
  always @(posedge clk) b1.mux_out <= b1.mux_a[b1.mux_sel];
  assign b0.mux_out = b0.mux_a[b0.mux_sel];

  bmi_bit_extract_seq #(.MUX_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  bmi_bit_extract_seq #(.MUX_LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s;
    logic [63:0] m;
    logic [63:0] r;
    logic [6:0]  p;
    int          d1;
    int          d0;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with both engines idle; that negedge is cycle 0.
  task automatic run_op(input string nm, input logic [63:0] s, input logic [63:0] m,
                        input logic [63:0] er, input logic [6:0] ep,
                        input int d1, input int d0, input bit repulse);
    int n1 = 0, n0 = 0, c1 = -1, c0 = -1, busy_err = 0, sel_err = 0;
    logic [63:0] r1 = 64'd0, r0 = 64'd0;
    logic [6:0]  p1 = 7'd0, p0 = 7'd0;
    start = 1'b1;
    src   = s;
    mask  = m;
    for (int c = 1; c <= d1 + 4; c++) begin
      @(negedge clk);
      if (b1.done) begin
        n1++;
        if (c1 < 0) begin c1 = c; r1 = b1.result; p1 = b1.popcnt; end
      end
      if (b0.done) begin
        n0++;
        if (c0 < 0) begin c0 = c; r0 = b0.result; p0 = b0.popcnt; end
      end
      if (b1.busy !== ((m != 64'd0) && (c < d1))) busy_err++;
      if (b0.busy !== ((m != 64'd0) && (c < d0))) busy_err++;
      if ((m == 64'd0) && ((b1.mux_sel != 6'd0) || (b0.mux_sel != 6'd0))) sel_err++;
      start = repulse && (c >= 2) && (c <= 5);
      src   = {$urandom, $urandom};
      mask  = {$urandom, $urandom};
    end
    start = 1'b0;
    chk({nm, " done_cycle_lat1"}, 64'(c1), 64'(d1));
    chk({nm, " done_cycle_lat0"}, 64'(c0), 64'(d0));
    chk({nm, " done_count_lat1"}, 64'(n1), 64'd1);
    chk({nm, " done_count_lat0"}, 64'(n0), 64'd1);
    chk({nm, " result_lat1"}, r1, er);
    chk({nm, " result_lat0"}, r0, er);
    chk({nm, " popcnt_lat1"}, 64'(p1), 64'(ep));
    chk({nm, " popcnt_lat0"}, 64'(p0), 64'(ep));
    chk({nm, " busy_profile"}, 64'(busy_err), 64'd0);
    chk({nm, " mux_sel_idle"}, 64'(sel_err), 64'd0);
    chk({nm, " result_hold_lat1"}, b1.result, er);
    chk({nm, " result_hold_lat0"}, b0.result, er);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " busy"},    64'({b1.busy, b0.busy}), 64'd0);
    chk({nm, " done"},    64'({b1.done, b0.done}), 64'd0);
    chk({nm, " result"},  b1.result | b0.result, 64'd0);
    chk({nm, " popcnt"},  64'(b1.popcnt | b0.popcnt), 64'd0);
    chk({nm, " mux_a"},   b1.mux_a | b0.mux_a, 64'd0);
    chk({nm, " mux_sel"}, 64'(b1.mux_sel | b0.mux_sel), 64'd0);
  endtask

  initial begin
    int ndone;
    logic [63:0] rs, rm, rr;
    logic [6:0]  rp;
    int h;

    vt[0] = '{64'hA5, 64'h0F, 64'h5, 7'd4, 6, 5};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h1, 7'd1, 66, 65};
    vt[2] = '{64'h1234, 64'h0, 64'h0, 7'd0, 1, 1};
    vt[3] = '{64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0123_4567, 7'd64, 66, 65};
    vt[4] = '{64'hF0, 64'hFF00, 64'h0, 7'd8, 18, 17};
    vt[5] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64'h3, 7'd2, 66, 65};
    vt[6] = '{64'hAA, 64'hAA, 64'hF, 7'd4, 10, 9};
    vt[7] = '{64'h1, 64'h1, 64'h1, 7'd1, 3, 2};
    vt[8] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_0000_0000, 64'h0123, 7'd16, 66, 65};

    repeat (2) @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vt[i].s, vt[i].m, vt[i].r, vt[i].p,
                                       vt[i].d1, vt[i].d0, 1'b0);

    // restart attempts while busy and in DONE, with operands scrambled after acceptance
    run_op("repulse", vt[0].s, vt[0].m, vt[0].r, vt[0].p, vt[0].d1, vt[0].d0, 1'b1);

    // mask==0 completes in cycle 1; a start held through DONE must only be taken in the next IDLE
    start = 1'b1; src = 64'h55; mask = 64'h0;
    @(negedge clk);
    chk("b2b zero_done", 64'({b1.done, b0.done}), 64'h3);
    src = vt[0].s; mask = vt[0].m;
    @(negedge clk);
    run_op("b2b", vt[0].s, vt[0].m, vt[0].r, vt[0].p, vt[0].d1, vt[0].d0, 1'b0);

    // reset in cycle 3 of the all-ones-mask operation
    start = 1'b1; src = vt[3].s; mask = vt[3].m;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (b1.done || b0.done) ndone++;
    end
    chk("mid_reset no_done", 64'(ndone), 64'd0);
    run_op("after_reset", vt[0].s, vt[0].m, vt[0].r, vt[0].p, vt[0].d1, vt[0].d0, 1'b0);

    for (int t = 0; t < 16; t++) begin
      rs = {$urandom, $urandom};
      rm = {$urandom, $urandom};
      if (t < 4) rm = rm & (64'hFF << (t * 8));
      rr = 64'd0; rp = 7'd0; h = -1;
      for (int b = 0; b < 64; b++) begin
        if (rm[b]) begin
          rr[rp[5:0]] = rs[b];
          rp = rp + 7'd1;
          h = b;
        end
      end
      if (h < 0) run_op($sformatf("rnd%0d", t), rs, rm, rr, rp, 1, 1, 1'b0);
      else       run_op($sformatf("rnd%0d", t), rs, rm, rr, rp, h + 3, h + 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
